// File: rtl/sga_pkg.sv
// Shared definitions for the Snake Game Arcade control unit: state codes,
// direction encodings and the opposite-direction helper.
package sga_pkg;

  typedef enum logic [4:0] {
    IDLE       = 5'd0,
    PREPARA    = 5'd1,
    GERA_MACA  = 5'd2,
    RENDERIZA  = 5'd3,
    ESPERA     = 5'd4,
    REGISTRA   = 5'd5,
    MOVE       = 5'd6,
    WRITE      = 5'd7,
    COMPARA    = 5'd8,
    COMEU_MACA = 5'd9,
    CRESCE     = 5'd10,
    PAUSOU     = 5'd11,
    PERDEU     = 5'd12,
    GANHOU     = 5'd13
  } state_t;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_UP    = 2'b11;

  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/sga_dir_queue.sv
// Buffered direction requests: validates single-button pulses against the
// most recent pending direction and holds up to DIR_DEPTH of them.
module sga_dir_queue
  import sga_pkg::*;
#(
  parameter int DIR_DEPTH = 2
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       flush,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       deq,
  input  logic [1:0] cur_dir,
  output logic [1:0] out_dir,
  output logic       out_valid
);

  // Storage is sized for the largest legal depth; DIR_DEPTH caps occupancy.
  logic [1:0] mem [4];
  logic [2:0] count;
  logic [1:0] tail;
  logic [1:0] req_dir;
  logic [1:0] ref_dir;
  logic       req_one;
  logic       full;
  logic       do_deq;
  logic       do_enq;

  always_comb begin
    req_one = 1'b1;
    req_dir = DIR_RIGHT;
    case ({btn_left, btn_right, btn_up, btn_down})
      4'b1000: req_dir = DIR_LEFT;
      4'b0100: req_dir = DIR_RIGHT;
      4'b0010: req_dir = DIR_UP;
      4'b0001: req_dir = DIR_DOWN;
      default: req_one = 1'b0;
    endcase
  end

  assign tail      = count[1:0] - 2'd1;
  assign ref_dir   = (count == 3'd0) ? cur_dir : mem[tail];
  assign full      = (count == 3'(DIR_DEPTH));
  assign do_deq    = deq && (count != 3'd0);
  assign do_enq    = req_one && (req_dir != ref_dir) && (req_dir != opposite(ref_dir))
                     && (!full || do_deq);
  assign out_dir   = mem[0];
  assign out_valid = (count != 3'd0);

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      count <= 3'd0;
      for (int i = 0; i < 4; i++) mem[i] <= DIR_RIGHT;
    end else if (flush) begin
      count <= 3'd0;
    end else begin
      if (do_deq) begin
        for (int i = 0; i < 3; i++) mem[i] <= mem[i+1];
      end
      // On a simultaneous dequeue the new entry lands one slot lower.
      if (do_enq) begin
        if (do_deq) mem[tail] <= req_dir;
        else        mem[count[1:0]] <= req_dir;
      end
      if (do_enq && !do_deq)      count <= count + 3'd1;
      else if (!do_enq && do_deq) count <= count - 3'd1;
    end
  end

endmodule

// File: rtl/sga_uc_param.sv
// Snake Game Arcade control unit: game FSM, length counter, move timer and
// segment index driving the body-RAM shift loop and the render loop.
module sga_uc_param
  import sga_pkg::*;
#(
  parameter int SIZE_W     = 6,
  parameter int INIT_SIZE  = 3,
  parameter int MAX_SIZE   = 64,
  parameter int TICK_W     = 24,
  parameter int PLAY_TICKS = 5000000,
  parameter int DIR_DEPTH  = 2
) (
  input  logic              clock,
  input  logic              restart_n,
  input  logic              start,
  input  logic              pause,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              played,
  input  logic              is_at_apple,
  input  logic              is_at_border,
  input  logic              is_at_body,
  output logic [SIZE_W-1:0] size,
  output logic [SIZE_W-1:0] seg_idx,
  output logic [1:0]        direction,
  output logic              register_head,
  output logic              register_apple,
  output logic              we_ram,
  output logic              mux_ram,
  output logic              render_en,
  output logic              finished,
  output logic              won,
  output logic              lost,
  output logic [4:0]        db_state
);

  localparam logic [SIZE_W-1:0] SEG_ONE   = SIZE_W'(1);
  localparam logic [SIZE_W-1:0] SIZE_INIT = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W:0]   SIZE_MAX  = (SIZE_W+1)'(MAX_SIZE);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PLAY_TICKS - 1);

  state_t            state, state_next;
  logic [TICK_W-1:0] timer;
  logic [SIZE_W:0]   size_inc;
  logic              move_due;
  logic              render_last;
  logic              flush;
  logic              deq;
  logic [1:0]        q_dir;
  logic              q_valid;

  assign size_inc    = {1'b0, size} + (SIZE_W+1)'(1);
  assign move_due    = (timer == TICK_LAST) || played;
  assign render_last = (seg_idx == size - SEG_ONE);
  assign flush       = (state == PREPARA);
  assign deq         = (state == REGISTRA);

  sga_dir_queue #(.DIR_DEPTH(DIR_DEPTH)) u_dir_queue (
    .clock     (clock),
    .restart_n (restart_n),
    .flush     (flush),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .deq       (deq),
    .cur_dir   (direction),
    .out_dir   (q_dir),
    .out_valid (q_valid)
  );

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next     = state;
    register_head  = 1'b0;
    register_apple = 1'b0;
    we_ram         = 1'b0;
    mux_ram        = 1'b0;
    render_en      = 1'b0;
    finished       = 1'b0;
    won            = 1'b0;
    lost           = 1'b0;
    case (state)
      IDLE:       if (start) state_next = PREPARA;
      PREPARA:    state_next = GERA_MACA;
      GERA_MACA: begin
        register_apple = 1'b1;
        state_next     = RENDERIZA;
      end
      RENDERIZA: begin
        render_en = 1'b1;
        if (render_last) state_next = ESPERA;
      end
      // A due move takes precedence over a pause request in the same cycle.
      ESPERA: begin
        if (move_due)   state_next = REGISTRA;
        else if (pause) state_next = PAUSOU;
      end
      PAUSOU:     if (start && !pause) state_next = ESPERA;
      REGISTRA: begin
        register_head = 1'b1;
        state_next    = MOVE;
      end
      MOVE: begin
        mux_ram    = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        mux_ram    = 1'b1;
        we_ram     = 1'b1;
        state_next = (seg_idx == '0) ? COMPARA : MOVE;
      end
      COMPARA: begin
        if (is_at_border || is_at_body) state_next = PERDEU;
        else if (is_at_apple)           state_next = COMEU_MACA;
        else                            state_next = RENDERIZA;
      end
      COMEU_MACA: state_next = CRESCE;
      CRESCE:     state_next = (size_inc == SIZE_MAX) ? GANHOU : GERA_MACA;
      PERDEU: begin
        finished = 1'b1;
        lost     = 1'b1;
        if (start) state_next = PREPARA;
      end
      GANHOU: begin
        finished = 1'b1;
        won      = 1'b1;
        if (start) state_next = PREPARA;
      end
      default:    state_next = IDLE;
    endcase
  end

  assign db_state = state;

  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      size      <= '0;
      seg_idx   <= '0;
      direction <= DIR_RIGHT;
      timer     <= '0;
    end else begin
      case (state)
        PREPARA: begin
          size      <= SIZE_INIT;
          direction <= DIR_RIGHT;
        end
        GERA_MACA: seg_idx <= '0;
        RENDERIZA: begin
          if (render_last) begin
            seg_idx <= '0;
            timer   <= '0;
          end else begin
            seg_idx <= seg_idx + SEG_ONE;
          end
        end
        ESPERA: if (!move_due && !pause) timer <= timer + TICK_W'(1);
        REGISTRA: begin
          if (q_valid) direction <= q_dir;
          seg_idx <= size - SEG_ONE;
        end
        WRITE:   if (seg_idx != '0) seg_idx <= seg_idx - SEG_ONE;
        COMPARA: seg_idx <= '0;
        CRESCE:  size <= size_inc[SIZE_W-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sga_uc_param.sv
// Directed bench for sga_uc_param with a short move period and a small win length.
module tb_sga_uc_param;

  localparam int SIZE_W = 4;

  logic              clock;
  logic              restart_n;
  logic              start, pause, played;
  logic              btn_left, btn_right, btn_up, btn_down;
  logic              is_at_apple, is_at_border, is_at_body;
  logic [SIZE_W-1:0] size, seg_idx;
  logic [1:0]        direction;
  logic              register_head, register_apple, we_ram, mux_ram, render_en;
  logic              finished, won, lost;
  logic [4:0]        db_state;

  int n_tests = 0;
  int n_fail  = 0;

  sga_uc_param #(
    .SIZE_W(SIZE_W), .INIT_SIZE(3), .MAX_SIZE(5),
    .TICK_W(8), .PLAY_TICKS(8), .DIR_DEPTH(2)
  ) dut (
    .clock(clock), .restart_n(restart_n), .start(start), .pause(pause),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .played(played), .is_at_apple(is_at_apple), .is_at_border(is_at_border),
    .is_at_body(is_at_body), .size(size), .seg_idx(seg_idx), .direction(direction),
    .register_head(register_head), .register_apple(register_apple), .we_ram(we_ram),
    .mux_ram(mux_ram), .render_en(render_en), .finished(finished), .won(won),
    .lost(lost), .db_state(db_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, db_state, 0);
    chk({tag, "_size"}, size, 0);
    chk({tag, "_seg"}, seg_idx, 0);
    chk({tag, "_dir"}, direction, 0);
    chk({tag, "_strobes"}, {register_head, register_apple, we_ram, mux_ram, render_en}, 0);
    chk({tag, "_status"}, {finished, won, lost}, 0);
  endtask

  // Entered with RENDERIZA just observed; leaves ESPERA observed.
  task automatic do_render(input int n);
    for (int i = 0; i < n; i++) begin
      chk("render_state", db_state, 3);
      chk("render_seg", seg_idx, i);
      chk("render_en", render_en, 1);
      step();
    end
    chk("espera_entry", db_state, 4);
    chk("render_off", render_en, 0);
    chk("espera_seg", seg_idx, 0);
  endtask

  // Entered with REGISTRA observed; leaves COMPARA observed.
  task automatic do_shift(input int n);
    chk("registra_head", register_head, 1);
    step();
    for (int i = n - 1; i >= 0; i--) begin
      chk("move_state", db_state, 6);
      chk("move_seg", seg_idx, i);
      chk("move_strobes", {mux_ram, we_ram}, 2'b10);
      step();
      chk("write_state", db_state, 7);
      chk("write_seg", seg_idx, i);
      chk("write_strobes", {mux_ram, we_ram}, 2'b11);
      step();
    end
    chk("compara_state", db_state, 8);
  endtask

  // From ESPERA entry observed, idle n-1 more cycles then expect REGISTRA.
  task automatic wait_timer(input int n);
    repeat (n - 1) step();
    chk("espera_hold", db_state, 4);
    step();
    chk("registra_entry", db_state, 5);
  endtask

  initial begin
    restart_n = 1'b0;
    {start, pause, played} = '0;
    {btn_left, btn_right, btn_up, btn_down} = '0;
    {is_at_apple, is_at_border, is_at_body} = '0;
    #1;
    chk_idle_outputs("reset_async");
    repeat (2) step();
    restart_n = 1'b1;
    step();
    chk_idle_outputs("reset_release");

    // Round 1: start, render 3 segments, natural timeout, shift loop.
    start = 1'b1;
    step();
    chk("prepara", db_state, 1);
    start = 1'b0;
    step();
    chk("gera_maca", db_state, 2);
    chk("register_apple", register_apple, 1);
    chk("size_init", size, 3);
    step();
    chk("apple_one_cycle", register_apple, 0);
    do_render(3);
    wait_timer(8);
    do_shift(3);
    chk("dir_r1", direction, 2'b00);
    step();

    // Round 2: LEFT rejected, UP and LEFT queued, DOWN dropped as queue is full.
    do_render(3);
    btn_left = 1'b1; step(); btn_left = 1'b0;
    btn_up   = 1'b1; step(); btn_up   = 1'b0;
    btn_left = 1'b1; step(); btn_left = 1'b0;
    btn_down = 1'b1; step(); btn_down = 1'b0;
    wait_timer(4);
    do_shift(3);
    chk("dir_up", direction, 2'b11);
    step();
    do_render(3);
    wait_timer(8);
    do_shift(3);
    chk("dir_left", direction, 2'b01);
    step();

    // Round 3: two buttons at once ignored; pause at timer 5 and resume.
    do_render(3);
    btn_up = 1'b1; btn_down = 1'b1; step(); btn_up = 1'b0; btn_down = 1'b0;
    repeat (4) step();
    chk("pre_pause", db_state, 4);
    pause = 1'b1;
    step();
    chk("pausou", db_state, 11);
    start = 1'b1;
    repeat (3) step();
    chk("pausou_hold", db_state, 11);
    pause = 1'b0;
    step();
    chk("resume", db_state, 4);
    start = 1'b0;
    wait_timer(3);
    do_shift(3);
    chk("dir_kept", direction, 2'b01);
    step();

    // Round 4: played beats pause; two apples reach the win length.
    do_render(3);
    pause = 1'b1; played = 1'b1;
    step();
    chk("played_beats_pause", db_state, 5);
    pause = 1'b0; played = 1'b0;
    do_shift(3);
    is_at_apple = 1'b1;
    step();
    chk("comeu_maca", db_state, 9);
    is_at_apple = 1'b0;
    step();
    chk("cresce", db_state, 10);
    step();
    chk("regen_apple", db_state, 2);
    chk("size_4", size, 4);
    step();
    do_render(4);
    played = 1'b1; step(); played = 1'b0;
    chk("registra_played", db_state, 5);
    do_shift(4);
    is_at_apple = 1'b1; step(); is_at_apple = 1'b0;
    step();
    chk("cresce_win", db_state, 10);
    step();
    chk("ganhou", db_state, 13);
    chk("won_status", {finished, won, lost}, 3'b110);
    chk("size_max", size, 5);
    step();
    chk("ganhou_hold", db_state, 13);
    start = 1'b1; step(); start = 1'b0;
    chk("replay_prepara", db_state, 1);
    step();
    chk("replay_size", size, 3);
    chk("replay_dir", direction, 2'b00);
    step();

    // Round 5: lose beats eat, then reset in the middle of the shift loop.
    do_render(3);
    played = 1'b1; step(); played = 1'b0;
    do_shift(3);
    is_at_apple = 1'b1; is_at_body = 1'b1;
    step();
    is_at_apple = 1'b0; is_at_body = 1'b0;
    chk("perdeu", db_state, 12);
    chk("lost_status", {finished, won, lost}, 3'b101);
    start = 1'b1; step(); start = 1'b0;
    chk("retry_prepara", db_state, 1);
    repeat (2) step();
    do_render(3);
    played = 1'b1; step(); played = 1'b0;
    btn_up = 1'b1; step(); btn_up = 1'b0;
    step();
    step();
    chk("mid_move_state", db_state, 6);
    chk("mid_move_seg", seg_idx, 1);
    restart_n = 1'b0;
    #1;
    chk_idle_outputs("reset_mid");
    step();
    restart_n = 1'b1;
    step();
    chk_idle_outputs("reset_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
